// File: rtl/eth_rx_ctrl.sv
// Receive-side sequencing helper for the Ethernet MAC RX state machine: field counters,
// inter-frame-gap tracking, destination-address filtering and per-frame status pulses.
module eth_rx_ctrl #(
  parameter int unsigned IFG_MIN = 24,
  parameter int unsigned CNT_W   = 16
) (
  input  logic             MRxClk,
  input  logic             Resetn,
  input  logic             MRxDV,
  input  logic [3:0]       MRxD,
  input  logic             StateIdle,
  input  logic             StatePreamble,
  input  logic             StateSFD,
  input  logic             StateDA,
  input  logic             StateSA,
  input  logic             StateLength,
  input  logic             StateDrop,
  input  logic [1:0]       StateData,
  input  logic [47:0]      MacAddr,
  input  logic             r_Pro,
  input  logic             r_IFG,
  input  logic [CNT_W-1:0] MaxFL,
  output logic [CNT_W-1:0] ByteCnt,
  output logic             Rx_NibCnt,
  output logic             ByteCntEq0,
  output logic             ByteCntGreat2,
  output logic             ByteCntMaxFrame,
  output logic             MRxDEq5,
  output logic             MRxDEqD,
  output logic             IFGCounterEq24,
  output logic             Frame_drop,
  output logic [15:0]      RxLength,
  output logic [CNT_W-1:0] RxDataCnt,
  output logic             RxFrameDone,
  output logic             RxFrameAbort
);

  localparam int unsigned ST_W  = 9;
  localparam int unsigned IFG_W = 5;
  localparam int unsigned S_IDLE = 0, S_PRE = 1, S_SFD = 2, S_DA = 3, S_SA = 4,
                          S_LEN = 5, S_D0 = 6, S_D1 = 7, S_DROP = 8;

  logic [ST_W-1:0]  stateVec, stateQ;
  logic [ST_W-2:0]  stateMrg, stateQMrg;
  logic             cntEntry, daEntry;
  logic             nibMode, byteMode, holdZero;
  logic [CNT_W-1:0] cntQ, byteInc;
  logic             nibQ;
  logic [IFG_W-1:0] ifgCnt;
  logic             addrOk, bcastOk;
  logic [7:0]       daByte;
  logic [3:0]       daNib;
  logic             daIdxOk;
  logic             doneCond, abortCond;

  assign stateVec = {StateDrop, StateData, StateLength, StateSA, StateDA,
                     StateSFD, StatePreamble, StateIdle};

  // DATA0 and DATA1 are folded together so byte counting continues across them
  assign stateMrg  = {stateVec[S_DROP], stateVec[S_D1] | stateVec[S_D0], stateVec[S_LEN:S_IDLE]};
  assign stateQMrg = {stateQ[S_DROP],   stateQ[S_D1]   | stateQ[S_D0],   stateQ[S_LEN:S_IDLE]};
  assign cntEntry  = (stateMrg != stateQMrg);
  assign daEntry   = StateDA & ~stateQ[S_DA];

  assign ByteCnt   = cntEntry ? '0 : cntQ;
  assign Rx_NibCnt = cntEntry ? 1'b0 : nibQ;
  assign byteInc   = (&ByteCnt) ? ByteCnt : ByteCnt + CNT_W'(1);

  assign nibMode  = StatePreamble | StateSFD;
  assign byteMode = StateDA | StateSA | StateLength | (|StateData);
  assign holdZero = StateIdle | StateDrop;

  assign ByteCntEq0      = (ByteCnt == '0);
  assign ByteCntGreat2   = (ByteCnt > CNT_W'(2));
  assign ByteCntMaxFrame = StateData[0] & (ByteCnt == MaxFL);
  assign MRxDEq5         = (MRxD == 4'h5);
  assign MRxDEqD         = (MRxD == 4'hD);
  assign IFGCounterEq24  = (ifgCnt == IFG_W'(IFG_MIN)) | r_IFG;
  assign Frame_drop      = StateSA & ~(addrOk | bcastOk | r_Pro);

  assign doneCond  = (stateQ[S_D0] | stateQ[S_D1]) & StateIdle;
  assign abortCond = StateDrop & (stateQ[S_PRE] | stateQ[S_SFD] | stateQ[S_DA] |
                                  stateQ[S_SA] | stateQ[S_LEN] | stateQ[S_D0]);

  // Station-address nibble expected at the current DA position
  always_comb begin
    daByte = 8'h00;
    case (ByteCnt)
      CNT_W'(0): daByte = MacAddr[47:40];
      CNT_W'(1): daByte = MacAddr[39:32];
      CNT_W'(2): daByte = MacAddr[31:24];
      CNT_W'(3): daByte = MacAddr[23:16];
      CNT_W'(4): daByte = MacAddr[15:8];
      CNT_W'(5): daByte = MacAddr[7:0];
      default:   daByte = 8'h00;
    endcase
  end

  assign daIdxOk = (ByteCnt < CNT_W'(6));
  assign daNib   = Rx_NibCnt ? daByte[7:4] : daByte[3:0];

  always_ff @(posedge MRxClk or negedge Resetn) begin
    if (!Resetn) stateQ <= '0;
    else         stateQ <= stateVec;
  end

  // Field counters; the effective value is stored back so a stalled entry cycle still reads 0
  always_ff @(posedge MRxClk or negedge Resetn) begin
    if (!Resetn) begin
      cntQ <= '0;
      nibQ <= 1'b0;
    end else if (holdZero) begin
      cntQ <= '0;
      nibQ <= 1'b0;
    end else if (MRxDV && nibMode) begin
      cntQ <= byteInc;
      nibQ <= 1'b0;
    end else if (MRxDV && byteMode) begin
      cntQ <= Rx_NibCnt ? byteInc : ByteCnt;
      nibQ <= ~Rx_NibCnt;
    end else begin
      cntQ <= ByteCnt;
      nibQ <= Rx_NibCnt;
    end
  end

  always_ff @(posedge MRxClk or negedge Resetn) begin
    if (!Resetn)                       ifgCnt <= '0;
    else if (MRxDV && !holdZero)       ifgCnt <= '0;
    else if (!MRxDV && ifgCnt < IFG_W'(IFG_MIN)) ifgCnt <= ifgCnt + IFG_W'(1);
  end

  always_ff @(posedge MRxClk or negedge Resetn) begin
    if (!Resetn) begin
      addrOk  <= 1'b0;
      bcastOk <= 1'b0;
    end else if (StateDA && MRxDV) begin
      addrOk  <= (daEntry | addrOk) & daIdxOk & (MRxD == daNib);
      bcastOk <= (daEntry | bcastOk) & (MRxD == 4'hF);
    end else if (daEntry) begin
      addrOk  <= 1'b1;
      bcastOk <= 1'b1;
    end
  end

  always_ff @(posedge MRxClk or negedge Resetn) begin
    if (!Resetn) begin
      RxLength <= '0;
    end else if (StateLength && MRxDV) begin
      case ({ByteCnt == CNT_W'(1), Rx_NibCnt})
        2'b00:   RxLength[11:8]  <= MRxD;
        2'b01:   RxLength[15:12] <= MRxD;
        2'b10:   RxLength[3:0]   <= MRxD;
        default: RxLength[7:4]   <= MRxD;
      endcase
    end
  end

  // cntQ already holds the last data byte count plus one when IDLE is first seen
  always_ff @(posedge MRxClk or negedge Resetn) begin
    if (!Resetn) begin
      RxDataCnt    <= '0;
      RxFrameDone  <= 1'b0;
      RxFrameAbort <= 1'b0;
    end else begin
      RxFrameDone  <= doneCond;
      RxFrameAbort <= abortCond;
      if (doneCond) RxDataCnt <= cntQ;
    end
  end

endmodule

// File: tb/tb_eth_rx_ctrl.sv
// Directed bench for eth_rx_ctrl: the bench plays the RX state machine and MII source;
// frame status pulses are checked by a scoreboard monitor, count flags inline per cycle.
module tb_eth_rx_ctrl;

  localparam int CNT_W = 16;
  localparam int S_IDLE = 0, S_PRE = 1, S_SFD = 2, S_DA = 3, S_SA = 4,
                 S_LEN = 5, S_D0 = 6, S_D1 = 7, S_DROP = 8;

  logic             MRxClk = 1'b0;
  logic             Resetn;
  logic             MRxDV;
  logic [3:0]       MRxD;
  logic             StateIdle, StatePreamble, StateSFD, StateDA, StateSA, StateLength, StateDrop;
  logic [1:0]       StateData;
  logic [47:0]      MacAddr;
  logic             r_Pro, r_IFG;
  logic [CNT_W-1:0] MaxFL;
  logic [CNT_W-1:0] ByteCnt;
  logic             Rx_NibCnt, ByteCntEq0, ByteCntGreat2, ByteCntMaxFrame;
  logic             MRxDEq5, MRxDEqD, IFGCounterEq24, Frame_drop;
  logic [15:0]      RxLength;
  logic [CNT_W-1:0] RxDataCnt;
  logic             RxFrameDone, RxFrameAbort;

  eth_rx_ctrl #(.IFG_MIN(24), .CNT_W(CNT_W)) dut (
    .MRxClk(MRxClk), .Resetn(Resetn), .MRxDV(MRxDV), .MRxD(MRxD),
    .StateIdle(StateIdle), .StatePreamble(StatePreamble), .StateSFD(StateSFD),
    .StateDA(StateDA), .StateSA(StateSA), .StateLength(StateLength), .StateDrop(StateDrop),
    .StateData(StateData), .MacAddr(MacAddr), .r_Pro(r_Pro), .r_IFG(r_IFG), .MaxFL(MaxFL),
    .ByteCnt(ByteCnt), .Rx_NibCnt(Rx_NibCnt), .ByteCntEq0(ByteCntEq0),
    .ByteCntGreat2(ByteCntGreat2), .ByteCntMaxFrame(ByteCntMaxFrame),
    .MRxDEq5(MRxDEq5), .MRxDEqD(MRxDEqD), .IFGCounterEq24(IFGCounterEq24),
    .Frame_drop(Frame_drop), .RxLength(RxLength), .RxDataCnt(RxDataCnt),
    .RxFrameDone(RxFrameDone), .RxFrameAbort(RxFrameAbort)
  );

  always #5 MRxClk = ~MRxClk;

  typedef struct packed {
    logic        isDone;
    logic [15:0] cnt;
    logic [15:0] len;
  } sb_t;

  sb_t  sbq[$];
  sb_t  monE;
  int   checks = 0;
  int   failures = 0;
  logic [15:0] lastCnt = '0;
  logic [15:0] lastLen = '0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h time=%0t", name, act, exp, $time);
    end
  endtask

  task automatic setState(input int s);
    StateIdle     = (s == S_IDLE);
    StatePreamble = (s == S_PRE);
    StateSFD      = (s == S_SFD);
    StateDA       = (s == S_DA);
    StateSA       = (s == S_SA);
    StateLength   = (s == S_LEN);
    StateData     = {s == S_D1, s == S_D0};
    StateDrop     = (s == S_DROP);
  endtask

  task automatic pushEv(input logic isDone, input logic [15:0] cnt, input logic [15:0] len);
    sb_t e;
    e.isDone = isDone;
    e.cnt    = cnt;
    e.len    = len;
    sbq.push_back(e);
  endtask

  // One receive clock: drive, sample combinational outputs mid-cycle, advance past the edge
  task automatic cyc(input int s, input logic dv, input logic [3:0] d, input int expCnt,
                     input logic expNib, input logic dropExp, input int ifgExp);
    setState(s);
    MRxDV = dv;
    MRxD  = d;
    @(negedge MRxClk);
    chk("byte_cnt", 32'(ByteCnt), 32'(expCnt));
    chk("nib_cnt", 32'(Rx_NibCnt), 32'(expNib));
    chk("cnt_eq0", 32'(ByteCntEq0), 32'(expCnt == 0));
    chk("cnt_great2", 32'(ByteCntGreat2), 32'(expCnt > 2));
    chk("cnt_maxframe", 32'(ByteCntMaxFrame), 32'((s == S_D0) && (expCnt == int'(MaxFL))));
    chk("mrxd_eq5", 32'(MRxDEq5), 32'(d == 4'h5));
    chk("mrxd_eqd", 32'(MRxDEqD), 32'(d == 4'hD));
    chk("frame_drop", 32'(Frame_drop), 32'((s == S_SA) && dropExp));
    if (ifgExp >= 0) chk("ifg_eq24", 32'(IFGCounterEq24), 32'(ifgExp));
    @(posedge MRxClk);
    #1;
  endtask

  task automatic idleFor(input int n, input int ifgExp);
    for (int i = 0; i < n; i++) cyc(S_IDLE, 1'b0, 4'h0, 0, 1'b0, 1'b0, ifgExp);
  endtask

  task automatic dropTail();
    for (int i = 0; i < 3; i++) cyc(S_DROP, 1'b1, 4'h3, 0, 1'b0, 1'b0, -1);
    cyc(S_IDLE, 1'b0, 4'h0, 0, 1'b0, 1'b0, -1);
  endtask

  // Full frame as the RX FSM would sequence it; abortAt<0 means no max-frame abort,
  // rstAtSa>=0 pulses reset at that SA nibble
  task automatic runFrame(input logic [47:0] da, input logic [15:0] len, input int nData,
                          input logic dropExp, input int abortAt, input int rstAtSa);
    logic [47:0] sh;
    logic [47:0] sa;
    logic [7:0]  b;
    logic [3:0]  nb;
    sa = 48'h0A1B2C3D4E5F;
    for (int i = 0; i < 14; i++) cyc(S_PRE, 1'b1, 4'h5, i, 1'b0, 1'b0, -1);
    cyc(S_SFD, 1'b1, 4'h5, 0, 1'b0, 1'b0, -1);
    cyc(S_SFD, 1'b1, 4'hD, 1, 1'b0, 1'b0, -1);
    for (int j = 0; j < 12; j++) begin
      sh = da >> (40 - 8 * (j / 2));
      b  = sh[7:0];
      nb = (j % 2 == 1) ? b[7:4] : b[3:0];
      cyc(S_DA, 1'b1, nb, j / 2, 1'((j % 2)), dropExp, -1);
    end
    for (int j = 0; j < 12; j++) begin
      if (j == rstAtSa) begin
        Resetn = 1'b0;
        setState(S_IDLE);
        MRxDV = 1'b0;
        #1;
        lastCnt = '0;
        lastLen = '0;
        chk("rst_byte_cnt", 32'(ByteCnt), 32'd0);
        chk("rst_nib_cnt", 32'(Rx_NibCnt), 32'd0);
        chk("rst_ifg_eq24", 32'(IFGCounterEq24), 32'd0);
        chk("rst_frame_drop", 32'(Frame_drop), 32'd0);
        chk("rst_rx_length", 32'(RxLength), 32'd0);
        chk("rst_rx_datacnt", 32'(RxDataCnt), 32'd0);
        chk("rst_pulses", 32'({RxFrameDone, RxFrameAbort}), 32'd0);
        @(posedge MRxClk);
        #1;
        Resetn = 1'b1;
        return;
      end
      sh = sa >> (40 - 8 * (j / 2));
      b  = sh[7:0];
      nb = (j % 2 == 1) ? b[7:4] : b[3:0];
      cyc(S_SA, 1'b1, nb, j / 2, 1'((j % 2)), dropExp, -1);
      if (dropExp) begin
        pushEv(1'b0, lastCnt, lastLen);
        dropTail();
        return;
      end
    end
    for (int j = 0; j < 4; j++) begin
      b  = (j < 2) ? len[15:8] : len[7:0];
      nb = (j % 2 == 1) ? b[7:4] : b[3:0];
      cyc(S_LEN, 1'b1, nb, j / 2, 1'((j % 2)), 1'b0, -1);
    end
    lastLen = len;
    for (int k = 0; k < nData; k++) begin
      b = 8'(k * 7 + 3);
      cyc(S_D0, 1'b1, b[3:0], k, 1'b0, 1'b0, -1);
      if (k == abortAt) begin
        pushEv(1'b0, lastCnt, lastLen);
        dropTail();
        return;
      end
      cyc(S_D1, 1'b1, b[7:4], k, 1'b1, 1'b0, -1);
    end
    lastCnt = 16'(nData);
    pushEv(1'b1, lastCnt, lastLen);
    cyc(S_IDLE, 1'b0, 4'h0, 0, 1'b0, 1'b0, -1);
  endtask

  // Scoreboard monitor: every status pulse must match the oldest expected event
  always @(negedge MRxClk) begin
    if (Resetn && (RxFrameDone || RxFrameAbort)) begin
      if (sbq.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_pulse done=%0b abort=%0b required=none time=%0t",
                 RxFrameDone, RxFrameAbort, $time);
      end else begin
        monE = sbq.pop_front();
        chk("pulse_done", 32'(RxFrameDone), 32'(monE.isDone));
        chk("pulse_abort", 32'(RxFrameAbort), 32'(!monE.isDone));
        chk("rx_datacnt", 32'(RxDataCnt), 32'(monE.cnt));
        chk("rx_length", 32'(RxLength), 32'(monE.len));
      end
    end
  end

  initial begin
    Resetn  = 1'b0;
    MRxDV   = 1'b0;
    MRxD    = 4'h0;
    setState(S_IDLE);
    MacAddr = 48'h001122334455;
    r_Pro   = 1'b0;
    r_IFG   = 1'b0;
    MaxFL   = 16'd1500;
    @(posedge MRxClk);
    @(posedge MRxClk);
    #1;
    chk("reset_byte_cnt", 32'(ByteCnt), 32'd0);
    chk("reset_rx_length", 32'(RxLength), 32'd0);
    chk("reset_rx_datacnt", 32'(RxDataCnt), 32'd0);
    chk("reset_pulses", 32'({RxFrameDone, RxFrameAbort}), 32'd0);
    chk("reset_ifg_eq24", 32'(IFGCounterEq24), 32'd0);
    chk("reset_frame_drop", 32'(Frame_drop), 32'd0);
    Resetn = 1'b1;

    for (int i = 0; i < 26; i++) cyc(S_IDLE, 1'b0, 4'h0, 0, 1'b0, 1'b0, (i >= 24) ? 1 : 0);

    runFrame(48'h001122334455, 16'h002E, 46, 1'b0, -1, -1);
    idleFor(3, -1);
    runFrame(48'h001122344455, 16'h002E, 46, 1'b1, -1, -1);
    idleFor(3, -1);
    r_Pro = 1'b1;
    runFrame(48'h001122344455, 16'h0030, 46, 1'b0, -1, -1);
    r_Pro = 1'b0;
    idleFor(3, -1);

    MacAddr = 48'hA1B2C3D4E5F6;
    runFrame(48'hFFFFFFFFFFFF, 16'h0040, 12, 1'b0, -1, -1);
    MacAddr = 48'h001122334455;
    idleFor(3, -1);

    MaxFL = 16'd10;
    runFrame(48'h001122334455, 16'h0014, 20, 1'b0, 10, -1);
    MaxFL = 16'd1500;

    idleFor(10, 0);
    runFrame(48'h001122334455, 16'h0800, 6, 1'b0, -1, -1);
    idleFor(10, 0);
    runFrame(48'h001122334455, 16'h0801, 5, 1'b0, -1, -1);
    r_IFG = 1'b1;
    idleFor(10, 1);
    runFrame(48'h001122334455, 16'h0800, 7, 1'b0, -1, -1);
    r_IFG = 1'b0;
    idleFor(3, -1);

    runFrame(48'h001122334455, 16'h0800, 8, 1'b0, -1, 4);
    for (int i = 0; i < 26; i++) cyc(S_IDLE, 1'b0, 4'h0, 0, 1'b0, 1'b0, (i >= 24) ? 1 : 0);
    runFrame(48'h001122334455, 16'h0022, 3, 1'b0, -1, -1);

    idleFor(4, -1);
    chk("scoreboard_drained", 32'(sbq.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
